// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the memory-mapped UART transmitter.
//   - tx_state_e   : transmit FSM states
//   - *_OFS        : register offsets within the 8-byte window
//   - ST_*_BIT     : STATUS register field positions
// Optional feature macro (used by uart_tx_mmio): UART_TX_PARITY_EN
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic [2:0] TXDATA_OFS = 3'd0;
   localparam logic [2:0] STATUS_OFS = 3'd4;

   localparam int unsigned ST_FULL_BIT  = 0;
   localparam int unsigned ST_EMPTY_BIT = 1;
   localparam int unsigned ST_BUSY_BIT  = 2;
   localparam int unsigned ST_OVF_BIT   = 3;
   localparam int unsigned ST_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through output.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   push, din      : write request and data (accepted when not full, or when popping)
//   pop            : read request (ignored when empty)
//   dout           : head entry, valid whenever !empty
//   full, empty    : occupancy flags
//   count          : number of stored entries (0..DEPTH)
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign empty = (r_count == '0);
   assign full  = (r_count == CW'(DEPTH));
   assign count = r_count;
   assign dout  = r_mem[r_rd_ptr];

   // A push at full is still accepted when the head leaves in the same cycle
   assign w_pop_ok  = pop && !empty;
   assign w_push_ok = push && (!full || w_pop_ok);

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers and occupancy count
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter (8N1, LSB first) with byte FIFO.
// Registers (offset = Mem_WrAddr[2]):
//   0 TXDATA : write pushes Mem_WrData[7:0]; reads 0
//   4 STATUS : {count @ [8+], overflow[3] (W1C), busy[2], empty[1], full[0]}
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   MemWrite          : CPU store strobe
//   Mem_WrAddr        : CPU data address (reads and writes)
//   Mem_WrData        : CPU store data
//   uart_sel          : combinational window hit
//   uart_rdata        : combinational read data, 0 when not selected
//   tx                : registered serial output, idle high
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (11-bit frame).
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Mem_WrAddr,
   input  logic [31:0] Mem_WrData,
   output logic        uart_sel,
   output logic [31:0] uart_rdata,
   output logic        tx
);

   localparam int unsigned BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH) + 1;

   tx_state_e           r_state, w_state_next;
   logic [BAUD_W-1:0]   r_baud, w_baud_next;
   logic [2:0]          r_idx, w_idx_next;
   logic [7:0]          r_shift, w_shift_next;
   logic                r_tx, w_tx_next;
   logic                r_ovf;
   logic                w_baud_exp;
   logic                w_pop;
   logic                w_push;
   logic                w_ovf_clr;
   logic                w_full, w_empty;
   logic [7:0]          w_dout;
   logic [COUNT_W-1:0]  w_count;
   logic [31:0]         w_status;
   logic                w_is_txdata, w_is_status;
   logic                w_unused;
`ifdef UART_TX_PARITY_EN
   logic                r_par, w_par_next;
`endif

   // Address decode: 8-byte window, word offset in bit 2
   assign uart_sel    = (Mem_WrAddr[31:3] == BASE_ADDR[31:3]);
   assign w_is_txdata = uart_sel && (Mem_WrAddr[2] == TXDATA_OFS[2]);
   assign w_is_status = uart_sel && (Mem_WrAddr[2] == STATUS_OFS[2]);
   assign w_push      = MemWrite && w_is_txdata;
   assign w_ovf_clr   = MemWrite && w_is_status && Mem_WrData[ST_OVF_BIT];
   assign w_unused    = ^{Mem_WrAddr[1:0], Mem_WrData[31:8]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   (Mem_WrData[7:0]),
      .pop   (w_pop),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // STATUS assembly and read mux
   always_comb begin
      w_status                          = '0;
      w_status[ST_FULL_BIT]             = w_full;
      w_status[ST_EMPTY_BIT]            = w_empty;
      w_status[ST_BUSY_BIT]             = (r_state != ST_IDLE);
      w_status[ST_OVF_BIT]              = r_ovf;
      w_status[ST_COUNT_LSB +: COUNT_W] = w_count;
      uart_rdata                        = w_is_status ? w_status : 32'h0;
   end

   assign w_baud_exp = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

   // Next-state, datapath and registered-tx logic
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_shift_next = r_shift;
      w_pop        = 1'b0;
      w_tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
      w_par_next   = r_par;
`endif
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_shift_next = w_dout;
               w_state_next = ST_START;
`ifdef UART_TX_PARITY_EN
               w_par_next   = ^w_dout;
`endif
            end
         end
         ST_START: begin
            if (w_baud_exp) begin
               w_idx_next   = 3'd0;
               w_state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_baud_exp) begin
               w_shift_next = {1'b0, r_shift[7:1]};
               w_idx_next   = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_next = ST_PARITY;
`else
                  w_state_next = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_baud_exp) w_state_next = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (w_baud_exp) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase

      // Baud counter restarts on every state entry and on each expiry
      if ((w_state_next != r_state) || w_baud_exp || (r_state == ST_IDLE)) begin
         w_baud_next = '0;
      end else begin
         w_baud_next = r_baud + BAUD_W'(1);
      end

      // tx is driven from the state being entered so it changes with the state
      case (w_state_next)
         ST_START:  w_tx_next = 1'b0;
         ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_tx_next = w_par_next;
`endif
         default:   w_tx_next = 1'b1;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         r_baud  <= w_baud_next;
         r_idx   <= w_idx_next;
         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
`ifdef UART_TX_PARITY_EN
         r_par   <= w_par_next;
`endif
      end
   end

   // Sticky overflow: set by a dropped push, cleared by W1C on STATUS
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
         r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign tx = r_tx;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Stimulus queues expected frames; a negedge monitor decodes tx and compares.
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CLKS = NBITS * CPB;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] Mem_WrAddr;
   logic [31:0] Mem_WrData;
   logic        uart_sel;
   logic [31:0] uart_rdata;
   logic        tx;

   uart_tx_mmio #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .MemWrite   (MemWrite),
      .Mem_WrAddr (Mem_WrAddr),
      .Mem_WrData (Mem_WrData),
      .uart_sel   (uart_sel),
      .uart_rdata (uart_rdata),
      .tx         (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   function automatic void fail(string name);
      n_total++;
      $display("FAIL %s: event did not occur as required", name);
   endfunction

   typedef struct {
      logic [7:0] data;
      int         gap;    // idle clocks before start, -1 = don't care
      bit         abort;  // frame expected to be cut by reset
   } exp_t;

   exp_t exp_q[$];

   function automatic void expect_frame(logic [7:0] d, int gap, bit ab);
      exp_t e;
      e.data  = d;
      e.gap   = gap;
      e.abort = ab;
      exp_q.push_back(e);
   endfunction

   // Monitor: sample tx once per cycle, collect a full frame, compare with queue head
   bit   mon_in_frame = 1'b0;
   int   mon_pos      = 0;
   int   mon_idle     = -1;
   int   mon_gap      = -1;
   logic mon_s [FRAME_CLKS];

   always @(negedge clk) begin : monitor
      exp_t       e;
      logic [7:0] d;
      bit         stable;
      if (reset) begin
         if (mon_in_frame) begin
            if (exp_q.size() == 0) fail("abort_without_expected_frame");
            else begin
               e = exp_q.pop_front();
               check("abort_expected", 32'(e.abort), 32'd1);
            end
         end
         mon_in_frame = 1'b0;
         mon_idle     = -1;
      end else if (!mon_in_frame) begin
         if (tx === 1'b0) begin
            mon_s[0]     = 1'b0;
            mon_pos      = 1;
            mon_gap      = mon_idle;
            mon_in_frame = 1'b1;
         end else if (mon_idle >= 0) begin
            mon_idle++;
         end
      end else begin
         mon_s[mon_pos] = tx;
         mon_pos++;
         if (mon_pos == FRAME_CLKS) begin
            mon_in_frame = 1'b0;
            mon_idle     = 0;
            stable       = 1'b1;
            for (int b = 0; b < NBITS; b++)
               for (int k = 1; k < CPB; k++)
                  if (mon_s[b*CPB+k] !== mon_s[b*CPB]) stable = 1'b0;
            for (int i = 0; i < 8; i++) d[i] = mon_s[(1+i)*CPB];
            check("bit_timing", 32'(stable), 32'd1);
            check("stop_bit", 32'(mon_s[(NBITS-1)*CPB]), 32'd1);
            if (exp_q.size() == 0) fail("unexpected_frame");
            else begin
               e = exp_q.pop_front();
               check("frame_not_aborted", 32'(e.abort), 32'd0);
               check("frame_data", 32'(d), 32'(e.data));
`ifdef UART_TX_PARITY_EN
               check("parity_bit", 32'(mon_s[9*CPB]), 32'(^e.data));
`endif
               if (e.gap >= 0) check("frame_gap", 32'(mon_gap), 32'(e.gap));
            end
         end
      end
   end

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      Mem_WrAddr = a;
      #1;
      v = uart_rdata;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Mem_WrAddr = a;
      Mem_WrData = d;
      MemWrite   = 1'b1;
      @(posedge clk);
      #1;
      MemWrite   = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      logic [31:0] v;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         rd(BASE + 32'd4, v);
         if (v == 32'h2 && !mon_in_frame) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail(name);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

   initial begin : stim
      logic [31:0] v;
      bit ok;
      reset      = 1'b1;
      MemWrite   = 1'b0;
      Mem_WrAddr = 32'h0;
      Mem_WrData = 32'h0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx", 32'(tx), 32'd1);
      rd(BASE + 32'd4, v);
      check("reset_status", v, 32'h2);
      check("reset_sel", 32'(uart_sel), 32'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      rd(BASE, v);
      check("txdata_read_zero", v, 32'h0);

      // Single byte 0xA5
      expect_frame(8'hA5, -1, 1'b0);
      wr(BASE, 32'hA5);
      rd(BASE + 32'd4, v);
      check("single_count_after_push", v, 32'h100);
      @(posedge clk);
      #1;
      rd(BASE + 32'd4, v);
      check("single_busy_after_pop", v, 32'h6);
      check("single_tx_start", 32'(tx), 32'd0);
      wait_idle("single_idle_timeout");

      // Burst of three consecutive stores
      expect_frame(8'h01, -1, 1'b0);
      expect_frame(8'h02, 1, 1'b0);
      expect_frame(8'h03, 1, 1'b0);
      wr(BASE, 32'h01);
      wr(BASE, 32'h02);
      wr(BASE, 32'h03);
      rd(BASE + 32'd4, v);
      check("burst_count_2", v, 32'h204);
      wait_idle("burst_idle_timeout");

      // Overflow: six pushes while the FSM is busy
      expect_frame(8'h10, -1, 1'b0);
      for (int i = 1; i < 5; i++) expect_frame(8'(8'h10 + i), 1, 1'b0);
      for (int i = 0; i < 6; i++) wr(BASE, 32'h10 + 32'(i));
      rd(BASE + 32'd4, v);
      check("overflow_status", v, 32'h40D);
      wr(BASE + 32'd4, 32'h8);
      rd(BASE + 32'd4, v);
      check("overflow_w1c", v, 32'h405);

      // Push coinciding with IDLE pop at full
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         rd(BASE + 32'd4, v);
         if (!v[2]) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) fail("full_pop_idle_timeout");
      expect_frame(8'h55, 1, 1'b0);
      wr(BASE, 32'h55);
      rd(BASE + 32'd4, v);
      check("push_pop_at_full", v, 32'h405);
      wait_idle("full_pop_drain_timeout");

      // Decode outside the window
      Mem_WrAddr = BASE + 32'd8;
      #1;
      check("decode_sel_off", 32'(uart_sel), 32'd0);
      check("decode_rdata_off", uart_rdata, 32'h0);
      wr(BASE + 32'd8, 32'h99);
      rd(BASE + 32'd4, v);
      check("decode_no_push", v, 32'h2);
      @(posedge clk);
      #1;
      rd(BASE + 32'd4, v);
      check("decode_still_idle", v, 32'h2);
      rd(BASE + 32'd5, v);
      check("decode_low_bits_ignored", v, 32'h2);
      rd(BASE - 32'd4, v);
      check("decode_below_base", 32'(uart_sel), 32'd0);

      // Byte with odd weight (parity 1 when enabled)
      expect_frame(8'h07, -1, 1'b0);
      wr(BASE, 32'h07);
      wait_idle("byte07_idle_timeout");

      // Reset during DATA bit 3; the queued 0x5A must be lost
      expect_frame(8'h3C, -1, 1'b1);
      wr(BASE, 32'h3C);
      wr(BASE, 32'h5A);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (tx === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) fail("reset_frame_start_timeout");
      repeat (17) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midframe_reset_tx", 32'(tx), 32'd1);
      rd(BASE + 32'd4, v);
      check("midframe_reset_status", v, 32'h2);
      reset = 1'b0;
      repeat (120) @(posedge clk);
      #1;
      check("post_reset_tx_idle", 32'(tx), 32'd1);
      check("pending_frames", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter with a byte FIFO, attached to the `riscv_cpu` data-memory port beside data RAM. A CPU store to `TXDATA` pushes a byte into the FIFO. An FSM drains the FIFO as 8N1 frames on `tx`, LSB first. A status register reports FIFO state, so firmware can poll before writing. The top-level read mux uses `uart_sel` to choose `uart_rdata` instead of RAM data.

## Interface
- `BASE_ADDR`, default 32'h0000_2000: 8-byte aligned base of the register window.
- `CLKS_PER_BIT`, default 16: clocks per serial bit. Must be ≥ 2.
- `FIFO_DEPTH`, default 16: number of FIFO entries. Power of two, ≥ 2.
- `clk` in 1: system clock, shared with the CPU.
- `reset` in 1: synchronous, active-high reset.
- `MemWrite` in 1: CPU store strobe, one cycle per store.
- `Mem_WrAddr` in 32: CPU data address, used for both reads and writes.
- `Mem_WrData` in 32: CPU store data.
- `uart_sel` out 1: combinational; high when `Mem_WrAddr[31:3] == BASE_ADDR[31:3]`.
- `uart_rdata` out 32: combinational register read data; zero when `uart_sel` is low.
- `tx` out 1: serial output, idle high.

## Operation
- Register decode:
  - Offset is `Mem_WrAddr[2]`; bits [1:0] are ignored.
  - Offset 0 is `TXDATA`.
  - Offset 4 is `STATUS`.
- `TXDATA`:
  - Write pushes `Mem_WrData[7:0]` into the FIFO.
  - Read returns 0.
- `STATUS` read fields:
  - bit0 full.
  - bit1 empty.
  - bit2 busy (FSM not in IDLE).
  - bit3 overflow (sticky).
  - bits[8 +: $clog2(FIFO_DEPTH)+1] FIFO count.
  - All other bits 0.
- `STATUS` write: W1C on bit3; all other bits ignored.
- Push acceptance:
  - A push is accepted when `!full || pop` in the same cycle.
  - A push in any other case is dropped and sets overflow.
  - Simultaneous push and pop at full: count stays at `FIFO_DEPTH` and overflow stays clear.
- FIFO:
  - Circular read and write pointers of `$clog2(FIFO_DEPTH)` bits, wrapping modulo depth.
  - Separate count register.
- FSM states: IDLE, START, DATA, PARITY (only when configured in), STOP.
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop the head into the shift register and go to START on the next cycle.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = `shift[0]`. Each time the baud counter expires, shift right and increment the index. After index 7 expires, go to PARITY if configured in, otherwise STOP.
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter:
  - Counts 0 .. `CLKS_PER_BIT`−1.
  - Cleared on every state entry.
  - "Expires" means the count equals `CLKS_PER_BIT`−1.
- Reset values:
  - `tx` = 1.
  - FSM in IDLE.
  - FIFO empty (pointers and count 0).
  - overflow = 0; baud counter, bit index and shift register = 0.
  - `uart_rdata` follows the decode rules above.
- Reset mid-frame: the frame is abandoned, `tx` returns to 1 on the next edge, and queued bytes are lost.

## Timing
- Reads are combinational, same cycle. This matches the single-cycle CPU.
- Push latency:
  - A write at edge N is visible in `STATUS` count after edge N.
  - If the FSM is in IDLE with an empty FIFO, the pop happens in the cycle after the push.
  - `tx` falls one cycle after the pop.
- Frame length:
  - 10 × `CLKS_PER_BIT` cycles without parity.
  - 11 × `CLKS_PER_BIT` cycles with parity.
- Back-to-back frames: exactly one extra idle-high clock (the IDLE pop cycle) between the end of STOP and the next START.
- busy is high from the START cycle through the last STOP cycle.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - PARITY state is compiled in, lasting `CLKS_PER_BIT` cycles.
  - `tx` = XOR of the 8 data bits (even parity).
  - Frame is 11 bits.
- Undefined: no PARITY state; the 8N1 frame is 10 bits.

## Structure
- Package `uart_pkg` holds:
  - FSM state enum.
  - Register offset constants `TXDATA_OFS` = 0 and `STATUS_OFS` = 4.
  - `STATUS` bit position constants.
- Sub-module `sync_fifo`, parameterised by width and depth. Ports:
  - `push`, `din`, `pop`, `dout`, `full`, `empty`, `count`.
  - First-word-fall-through `dout`.
- The top-level block holds decode, status, overflow and the transmit FSM.

## Test plan
Bench uses `CLKS_PER_BIT` = 4 and `FIFO_DEPTH` = 4.
- Single byte: after reset, store 0xA5 to `BASE_ADDR`.
  - `tx` sequence, 4 clocks each: 0, 1,0,1,0,0,1,0,1, 1.
  - `STATUS` busy then clears; empty = 1.
- Burst: store 0x01, 0x02, 0x03 on consecutive cycles.
  - `STATUS` count reads 2 after the first pop.
  - Three frames, each separated by exactly 1 idle clock.
- Overflow: hold the FSM busy and push 6 bytes.
  - Count saturates at 4 and bit3 = 1.
  - Writing 0x8 to `BASE_ADDR`+4 clears bit3.
- Push with pop at full: FIFO full, IDLE pop coincides with a store of 0x55.
  - Count stays 4, bit3 stays 0, and 0x55 is transmitted last.
- Decode: store to `BASE_ADDR`+8.
  - No push and `uart_sel` = 0.
  - Read of `BASE_ADDR`+4 on an empty idle block returns 32'h0000_0002.
- Reset mid-frame: assert `reset` during DATA bit 3.
  - `tx` = 1 on the next edge, `STATUS` = 0x2, no further frames.
  - With `UART_TX_PARITY_EN`: byte 0x07 gives parity bit 1 and an 11-bit frame.
